text_pixel_gen: RTL

- Text-mode renderer for the HDMI display path.
- Converts the timing generator's pixel position into a 4-bit VGA palette index per pixel, which feeds the downstream palette-to-RGB lookup.
- Fetches character/attribute words from a synchronous text RAM and glyph rows from a synchronous font ROM.
- Delays hs/vs/de so they stay aligned with the index.

---
 rtl/text_pixel_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/text_pixel_gen.sv
// Text-mode renderer: pixel position -> text RAM -> font ROM -> 4-bit palette index, 5-clock latency.
// Optional macro TEXT_CURSOR_EN adds an underline cursor on glyph rows 14-15 of one character cell.
module text_pixel_gen #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x_in,
    input  logic [9:0]  y_in,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
`ifdef TEXT_CURSOR_EN
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
`endif
    output logic [11:0] text_addr,
    input  logic [15:0] text_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  color_index,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);
    localparam logic [6:0]  COLS_L = 7'(COLS);
    localparam logic [5:0]  ROWS_L = 6'(ROWS);
    localparam logic [11:0] COLS_W = 12'(COLS);
`ifdef TEXT_CURSOR_EN
    localparam int Y_STAGES = 4;
`else
    localparam int Y_STAGES = 2;
`endif

    logic [11:0]                r_text_addr;
    logic [11:0]                r_font_addr;
    logic [3:0][2:0]            r_x_pipe;
    logic [Y_STAGES-1:0][3:0]   r_y_pipe;
    logic [3:0]                 r_de_pipe;
    logic [3:0]                 r_hs_pipe;
    logic [3:0]                 r_vs_pipe;
    logic [3:0]                 r_fg3;
    logic [3:0]                 r_fg4;
    logic [2:0]                 r_bg3;
    logic [2:0]                 r_bg4;
    logic                       r_blink3;
    logic                       r_blink4;
    logic [3:0]                 r_color;
    logic                       r_de_out;
    logic                       r_hs_out;
    logic                       r_vs_out;
    logic                       r_vs_prev;
    logic [FCW-1:0]             r_frame_cnt;
    logic                       r_blink_phase;

    logic [11:0] w_text_addr;
    logic        w_in_area;
    logic        w_glyph_bit;
    logic        w_pixel;
    logic [3:0]  w_bg_idx;
    logic [3:0]  w_fg_eff;

    assign w_text_addr = {6'd0, y_in[9:4]} * COLS_W + {5'd0, x_in[9:3]};
    // Off-screen positions are blanked so illegal input can never show stray glyphs.
    assign w_in_area   = (x_in[9:3] < COLS_L) && (y_in[9:4] < ROWS_L);

    assign w_glyph_bit = font_data[3'd7 - r_x_pipe[3]];
    assign w_bg_idx    = {1'b0, r_bg4};
    assign w_fg_eff    = (r_blink4 && r_blink_phase) ? w_bg_idx : r_fg4;

`ifdef TEXT_CURSOR_EN
    logic [3:0] r_cur_pipe;
    logic       w_cell_hit;

    assign w_cell_hit = (x_in[9:3] == cursor_col) && (y_in[9:4] == {1'b0, cursor_row});
    assign w_pixel    = w_glyph_bit | (r_cur_pipe[3] && (r_y_pipe[3] >= 4'd14) && !r_blink_phase);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_pipe <= '0;
        end else begin
            r_cur_pipe <= {r_cur_pipe[2:0], w_cell_hit};
        end
    end
`else
    assign w_pixel = w_glyph_bit;
`endif

    // Pipeline: E1 text address, E3 font address + attributes, E5 palette index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_text_addr <= '0;
            r_font_addr <= '0;
            r_x_pipe    <= '0;
            r_y_pipe    <= '0;
            r_de_pipe   <= '0;
            r_hs_pipe   <= '0;
            r_vs_pipe   <= '0;
            r_fg3       <= '0;
            r_fg4       <= '0;
            r_bg3       <= '0;
            r_bg4       <= '0;
            r_blink3    <= 1'b0;
            r_blink4    <= 1'b0;
            r_color     <= '0;
            r_de_out    <= 1'b0;
            r_hs_out    <= 1'b0;
            r_vs_out    <= 1'b0;
        end else begin
            r_text_addr <= w_text_addr;
            r_x_pipe    <= {r_x_pipe[2:0], x_in[2:0]};
            r_y_pipe    <= {r_y_pipe[Y_STAGES-2:0], y_in[3:0]};
            r_de_pipe   <= {r_de_pipe[2:0], de_in & w_in_area};
            r_hs_pipe   <= {r_hs_pipe[2:0], hs_in};
            r_vs_pipe   <= {r_vs_pipe[2:0], vs_in};
            r_font_addr <= {text_data[7:0], r_y_pipe[1]};
            r_fg3       <= text_data[11:8];
            r_bg3       <= text_data[14:12];
            r_blink3    <= text_data[15];
            r_fg4       <= r_fg3;
            r_bg4       <= r_bg3;
            r_blink4    <= r_blink3;
            r_de_out    <= r_de_pipe[3];
            r_hs_out    <= r_hs_pipe[3];
            r_vs_out    <= r_vs_pipe[3];
            if (!r_de_pipe[3]) begin
                r_color <= 4'd0;
            end else begin
                r_color <= w_pixel ? w_fg_eff : w_bg_idx;
            end
        end
    end

    // Blink phase flips only on a vsync rising edge, i.e. during blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev     <= 1'b0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_vs_prev <= vs_in;
            if (vs_in && !r_vs_prev) begin
                if (r_frame_cnt == FRAME_LAST) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign text_addr   = r_text_addr;
    assign font_addr   = r_font_addr;
    assign color_index = r_color;
    assign de_out      = r_de_out;
    assign hs_out      = r_hs_out;
    assign vs_out      = r_vs_out;

endmodule
